move_objeto: RTL and testbench

Movement controller for the on-screen square object; it consumes the four collision flags from the collision detector.
- Direction keys are sampled once per movement tick; a step is applied only in directions whose collision flag is clear.
- Position is clamped to the visible area.
- Registered xPos/yPos feed both the collision detector and the VGA pixel renderer.
- Closes the loop: keys plus collision flags in, position out.

---
 rtl/move_pkg.sv | 49 ++++
 rtl/move_objeto_gera_tick.sv | 29 ++
 rtl/move_objeto.sv | 160 ++++++++++++++++
 tb/tb_move_objeto.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// Shared definitions for the square-object movement path: screen limits
// (also used by the collision detector), position widths, the estado
// encoding and the clamp helper used on both axes.
package move_pkg;

   // Visible-area limits in pixels
   localparam int MONITOR_MIN_X = 1;
   localparam int MONITOR_MAX_X = 640;
   localparam int MONITOR_MIN_Y = 1;
   localparam int MONITOR_MAX_Y = 480;

   // Position register widths and the signed width used for position arithmetic
   localparam int X_W    = 10;
   localparam int Y_W    = 9;
   localparam int CALC_W = 12;

   // Limits pre-cast to the arithmetic width
   localparam logic signed [CALC_W-1:0] MIN_X_C = CALC_W'(MONITOR_MIN_X);
   localparam logic signed [CALC_W-1:0] MAX_X_C = CALC_W'(MONITOR_MAX_X);
   localparam logic signed [CALC_W-1:0] MIN_Y_C = CALC_W'(MONITOR_MIN_Y);
   localparam logic signed [CALC_W-1:0] MAX_Y_C = CALC_W'(MONITOR_MAX_Y);

   typedef enum logic [1:0] {
      PARADO    = 2'd0,
      MOVENDO   = 2'd1,
      BLOQUEADO = 2'd2
   } estado_t;

   // Clamp a candidate position into [lo, hi]. When the object is too large
   // to fit (hi below lo) the current position is kept instead.
   function automatic logic signed [CALC_W-1:0] clamp_pos(
      input logic signed [CALC_W-1:0] val,
      input logic signed [CALC_W-1:0] lo,
      input logic signed [CALC_W-1:0] hi,
      input logic signed [CALC_W-1:0] cur
   );
      logic signed [CALC_W-1:0] res;
      if (hi < lo)
         res = cur;
      else if (val < lo)
         res = lo;
      else if (val > hi)
         res = hi;
      else
         res = val;
      return res;
   endfunction

endpackage

// File: rtl/move_objeto_gera_tick.sv
// gera_tick: free-running divider producing a one-cycle pulse every
// STEP_DIV clock cycles. The pulse is high while the counter sits at
// STEP_DIV-1; with STEP_DIV=1 it is high every cycle.
module gera_tick #(
   parameter int STEP_DIV = 416000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   // Counter runs 0..STEP_DIV-1 and wraps, independent of any other input
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/move_objeto.sv
// move_objeto: keyboard-driven movement of the on-screen square. On each
// movement tick the held direction keys are combined with the collision
// flags, the new position is clamped to the visible area and estado reports
// whether the object is idle, moving or blocked.
// Optional build macro MOVE_OBJETO_ACCEL_EN: step doubles after every
// ACCEL_TICKS consecutive moving ticks (up to 4*STEP).
module move_objeto
   import move_pkg::*;
#(
   parameter int STEP_DIV    = 416000,
   parameter int STEP        = 2,
   parameter int X_INIT      = 320,
   parameter int Y_INIT      = 240,
   parameter int ACCEL_TICKS = 8
) (
   input  logic           VGA_clk,
   input  logic           reset,
   input  logic [6:0]     tamanho,
   input  logic           key_right,
   input  logic           key_left,
   input  logic           key_down,
   input  logic           key_up,
   input  logic           colisao_max_x,
   input  logic           colisao_min_x,
   input  logic           colisao_max_y,
   input  logic           colisao_min_y,
   output logic [X_W-1:0] xPos,
   output logic [Y_W-1:0] yPos,
   output logic [1:0]     estado
);

   localparam logic signed [CALC_W-1:0] STEP_C = CALC_W'(STEP);

   logic tick;

   gera_tick #(
      .STEP_DIV(STEP_DIV)
   ) u_gera_tick (
      .clk   (VGA_clk),
      .reset (reset),
      .tick  (tick)
   );

   estado_t                  estado_q;
   estado_t                  estado_next;
   logic [X_W-1:0]           x_next;
   logic [Y_W-1:0]           y_next;
   logic signed [CALC_W-1:0] step;
   logic signed [CALC_W-1:0] dx;
   logic signed [CALC_W-1:0] dy;
   logic signed [CALC_W-1:0] x_cur;
   logic signed [CALC_W-1:0] y_cur;
   logic signed [CALC_W-1:0] x_hi;
   logic signed [CALC_W-1:0] y_hi;
   logic signed [CALC_W-1:0] x_new;
   logic signed [CALC_W-1:0] y_new;
   logic                     any_key;
   logic                     changed;

   assign estado = estado_q;

`ifdef MOVE_OBJETO_ACCEL_EN
   localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
   localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);
   localparam logic signed [CALC_W-1:0] STEP_MAX  = CALC_W'(4 * STEP);

   logic [HOLD_W-1:0]        hold_cnt;
   logic [HOLD_W-1:0]        hold_next;
   logic signed [CALC_W-1:0] step_next;

   // Acceleration: count consecutive moving ticks, double step each time the
   // run reaches ACCEL_TICKS; any idle or blocked tick drops back to STEP
   always_comb begin
      hold_next = hold_cnt;
      step_next = step;
      if (tick) begin
         if (estado_next == MOVENDO) begin
            if (hold_cnt == HOLD_LAST) begin
               hold_next = '0;
               if (step < STEP_MAX)
                  step_next = step <<< 1;
            end else begin
               hold_next = hold_cnt + HOLD_W'(1);
            end
         end else begin
            hold_next = '0;
            step_next = STEP_C;
         end
      end
   end

   // Acceleration state register
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
         step     <= STEP_C;
      end else begin
         hold_cnt <= hold_next;
         step     <= step_next;
      end
   end
`else
   assign step = STEP_C;
`endif

   // Per-axis step request and clamped candidate position
   always_comb begin
      dx = '0;
      dy = '0;
      if (key_right && !key_left && !colisao_max_x)
         dx = step;
      else if (key_left && !key_right && !colisao_min_x)
         dx = -step;
      if (key_down && !key_up && !colisao_max_y)
         dy = step;
      else if (key_up && !key_down && !colisao_min_y)
         dy = -step;

      x_cur = $signed({2'b00, xPos});
      y_cur = $signed({3'b000, yPos});
      x_hi  = MAX_X_C - $signed({5'b00000, tamanho});
      y_hi  = MAX_Y_C - $signed({5'b00000, tamanho});
      x_new = clamp_pos(x_cur + dx, MIN_X_C, x_hi, x_cur);
      y_new = clamp_pos(y_cur + dy, MIN_Y_C, y_hi, y_cur);

      any_key = key_right | key_left | key_down | key_up;
      changed = (x_new != x_cur) || (y_new != y_cur);
   end

   // Next position and estado: only a tick changes anything
   always_comb begin
      x_next      = xPos;
      y_next      = yPos;
      estado_next = estado_q;
      if (tick) begin
         x_next = x_new[X_W-1:0];
         y_next = y_new[Y_W-1:0];
         if (!any_key)
            estado_next = PARADO;
         else if (changed)
            estado_next = MOVENDO;
         else
            estado_next = BLOQUEADO;
      end
   end

   // Position and estado registers
   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         xPos     <= X_W'(X_INIT);
         yPos     <= Y_W'(Y_INIT);
         estado_q <= PARADO;
      end else begin
         xPos     <= x_next;
         yPos     <= y_next;
         estado_q <= estado_next;
      end
   end

endmodule

// File: tb/tb_move_objeto.sv
// Directed bench for move_objeto with STEP_DIV=4, STEP=2, tamanho=20.
// Instance dut starts at 320/240; instance dut_b starts at x=619 for the
// right-edge clamp case. Both see the same stimulus.
module tb_move_objeto;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] tamanho;
   logic       key_right, key_left, key_down, key_up;
   logic       colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y;
   logic [9:0] x_a, x_b;
   logic [8:0] y_a, y_b;
   logic [1:0] e_a, e_b;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MOVE_OBJETO_ACCEL_EN
   int acc_d[7] = '{2, 2, 4, 4, 8, 8, 8};
`else
   int acc_d[7] = '{2, 2, 2, 2, 2, 2, 2};
`endif

   always #5 clk = ~clk;

   move_objeto #(
      .STEP_DIV(4), .STEP(2), .X_INIT(320), .Y_INIT(240), .ACCEL_TICKS(2)
   ) dut (
      .VGA_clk(clk), .reset(reset), .tamanho(tamanho),
      .key_right(key_right), .key_left(key_left), .key_down(key_down), .key_up(key_up),
      .colisao_max_x(colisao_max_x), .colisao_min_x(colisao_min_x),
      .colisao_max_y(colisao_max_y), .colisao_min_y(colisao_min_y),
      .xPos(x_a), .yPos(y_a), .estado(e_a)
   );

   move_objeto #(
      .STEP_DIV(4), .STEP(2), .X_INIT(619), .Y_INIT(240), .ACCEL_TICKS(2)
   ) dut_b (
      .VGA_clk(clk), .reset(reset), .tamanho(tamanho),
      .key_right(key_right), .key_left(key_left), .key_down(key_down), .key_up(key_up),
      .colisao_max_x(colisao_max_x), .colisao_min_x(colisao_min_x),
      .colisao_max_y(colisao_max_y), .colisao_min_y(colisao_min_y),
      .xPos(x_b), .yPos(y_b), .estado(e_b)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic inputs_idle();
      key_right = 0; key_left = 0; key_down = 0; key_up = 0;
      colisao_max_x = 0; colisao_min_x = 0; colisao_max_y = 0; colisao_min_y = 0;
   endtask

   // Leaves the bench on the negedge where reset drops; tick edges are then
   // the 4th, 8th, ... posedges.
   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      cycles(2);
      reset = 0;
   endtask

   initial begin
      int exp_x, exp_y;
      tamanho = 7'd20;
      inputs_idle();
      reset = 1;

      // 1. reset state, then idle running
      #12;
      check("rst_x", x_a, 320);
      check("rst_y", y_a, 240);
      check("rst_estado", e_a, 0);
      @(negedge clk);
      reset = 0;
      cycles(16);
      check("idle_x", x_a, 320);
      check("idle_y", y_a, 240);
      check("idle_estado", e_a, 0);

      // 2. key_right for 5 ticks, one change per 4 cycles
      inputs_idle();
      do_reset();
      key_right = 1;
      exp_x = 320;
      for (int k = 0; k < 5; k++) begin
         cycles(3);
         check("right_hold_x", x_a, exp_x);
         cycles(1);
         exp_x = exp_x + acc_d[k];
         check("right_step_x", x_a, exp_x);
         check("right_estado", e_a, 1);
      end
      check("right_y", y_a, 240);

      // 3. clamp at right edge, then collision, then clamp-only block
      inputs_idle();
      do_reset();
      key_right = 1;
      cycles(4);
      check("clamp_x", x_b, 620);
      check("clamp_estado", e_b, 1);
      colisao_max_x = 1;
      cycles(4);
      check("coll_x", x_b, 620);
      check("coll_estado", e_b, 2);
      colisao_max_x = 0;
      cycles(4);
      check("edge_x", x_b, 620);
      check("edge_estado", e_b, 2);

      // 4. diagonal degraded by x collision, then opposite keys cancel
      inputs_idle();
      do_reset();
      key_right = 1; key_down = 1; colisao_max_x = 1;
      cycles(4);
      check("diag_x1", x_a, 320);
      check("diag_y1", y_a, 242);
      check("diag_estado", e_a, 1);
      cycles(4);
      check("diag_x2", x_a, 320);
      check("diag_y2", y_a, 244);
      key_down = 0; key_left = 1; colisao_max_x = 0;
      cycles(4);
      check("cancel_x", x_a, 320);
      check("cancel_y", y_a, 244);
      check("cancel_estado", e_a, 2);
      inputs_idle();
      key_up = 1; colisao_min_y = 1;
      cycles(4);
      check("top_coll_y", y_a, 244);
      check("top_coll_estado", e_a, 2);
      inputs_idle();
      cycles(4);
      check("release_estado", e_a, 0);

      // 5. asynchronous reset mid-count while moving
      inputs_idle();
      do_reset();
      key_right = 1;
      cycles(4);
      check("pre_rst_x", x_a, 322);
      cycles(2);
      #2 reset = 1;
      #1;
      check("async_x", x_a, 320);
      check("async_y", y_a, 240);
      check("async_estado", e_a, 0);
      @(negedge clk);
      reset = 0;
      cycles(3);
      check("post_rst_hold_x", x_a, 320);
      cycles(1);
      check("post_rst_tick_x", x_a, 322);
      check("post_rst_estado", e_a, 1);

      // 6. long key_up hold (accelerating when the option is built in)
      inputs_idle();
      do_reset();
      key_up = 1;
      exp_y = 240;
      for (int k = 0; k < 7; k++) begin
         cycles(4);
         exp_y = exp_y - acc_d[k];
         check("up_y", y_a, exp_y);
         check("up_estado", e_a, 1);
      end
      key_up = 0;
      cycles(4);
      check("up_release_estado", e_a, 0);
      check("up_release_y", y_a, exp_y);
      key_up = 1;
      cycles(4);
      check("up_repress_y", y_a, exp_y - 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
